pi_lock_sequencer: RTL

Lock-acquisition controller for one `picore` servo channel. It drives the core's `enable`, `sclr` and output-offset load controls. Under `lock_request` it clears the integrator, sweeps the output offset in a triangle until the centered error falls inside a capture window, and then engages the PI loop. It monitors saturation and re-acquires automatically when lock is lost. It sits between host configuration registers and the `picore` instance.

---
 rtl/pi_seq_pkg.sv | 29 ++
 rtl/offset_sweeper.sv | 68 ++++++
 rtl/pi_lock_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pi_seq_pkg.sv
// Shared definitions for the pi_lock_sequencer slice.
//   - state_e        : sequencer state encodings (visible on the `state` port)
//   - *_DEF          : default values for the top-level parameters
//   - abs17()        : 17-bit magnitude of a signed 16-bit sample
package pi_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_SEARCH  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_LOCKED  = 3'd4
  } state_e;

  localparam int          SAT_LIMIT_DEF      = 16;
  localparam int          SETTLE_UPDATES_DEF = 64;
  localparam logic [15:0] ERR_WINDOW_DEF     = 16'd500;
  localparam logic [15:0] SEARCH_STEP_DEF    = 16'h0040;
  localparam logic [15:0] SEARCH_MIN_DEF     = 16'h1000;
  localparam logic [15:0] SEARCH_MAX_DEF     = 16'hF000;

  // Extra bit so -32768 maps to +32768 instead of wrapping back negative.
  function automatic logic [16:0] abs17(input logic signed [15:0] v);
    logic [16:0] w;
    w = {v[15], v};
    return v[15] ? (17'd0 - w) : w;
  endfunction

endpackage

// File: rtl/offset_sweeper.sv
// Triangle sweep generator for the core's output offset.
// Ports:
//   clk, sclr_n : clock, synchronous active-low reset
//   load_min    : restart the sweep at MIN, direction up
//   step        : advance one STEP in the current direction, bouncing at MIN/MAX
//   offset      : registered offset value
//   step_done   : one-cycle strobe, high in the cycle `offset` shows the new value
module offset_sweeper #(
  parameter logic [15:0] STEP = 16'h0040,
  parameter logic [15:0] MIN  = 16'h1000,
  parameter logic [15:0] MAX  = 16'hF000
) (
  input  logic        clk,
  input  logic        sclr_n,
  input  logic        load_min,
  input  logic        step,
  output logic [15:0] offset,
  output logic        step_done
);

  logic [15:0] r_offset;
  logic        r_up;
  logic        r_done;
  logic [16:0] w_up_nxt;
  logic [16:0] w_dn_nxt;

  // 17-bit arithmetic: carry out of the add or borrow out of the subtract
  // shows up in bit 16, so neither direction can wrap silently.
  always_comb begin
    w_up_nxt = {1'b0, r_offset} + {1'b0, STEP};
    w_dn_nxt = {1'b0, r_offset} - {1'b0, STEP};
  end

  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      r_offset <= '0;
      r_up     <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_done <= load_min | step;
      if (load_min) begin
        r_offset <= MIN;
        r_up     <= 1'b1;
      end else if (step) begin
        if (r_up) begin
          if (w_up_nxt > {1'b0, MAX}) begin
            r_up     <= 1'b0;
            r_offset <= w_dn_nxt[15:0];
          end else begin
            r_offset <= w_up_nxt[15:0];
          end
        end else begin
          // bit 16 set means the subtract borrowed: definitely below MIN
          if (w_dn_nxt[16] || (w_dn_nxt < {1'b0, MIN})) begin
            r_up     <= 1'b1;
            r_offset <= w_up_nxt[15:0];
          end else begin
            r_offset <= w_dn_nxt[15:0];
          end
        end
      end
    end
  end

  assign offset    = r_offset;
  assign step_done = r_done;

endmodule

// File: rtl/pi_lock_sequencer.sv
// Lock-acquisition controller for one picore servo channel.
// Clears the integrator, sweeps the output offset until |error| is inside the
// capture window, lets the PI loop settle, then holds lock while watching for
// sustained saturation, re-acquiring automatically when lock is lost.
// Ports:
//   clk, sclr_n            : clock, synchronous active-low reset
//   lock_request           : level, low forces IDLE
//   errorsig/_valid        : centered error sample and its strobe
//   pi_regout_update       : core output-update strobe
//   pi_overflow/underflow  : core saturation flags
//   pi_enable, pi_sclr     : core enable and one-cycle clear
//   pi_output_offset       : offset presented to the core
//   pi_set_output_offset/clk : identical one-cycle offset load strobes
//   locked, state          : status
//   relock_count           : saturating count of automatic re-acquisitions
module pi_lock_sequencer
  import pi_seq_pkg::*;
#(
  parameter int          SAT_LIMIT      = SAT_LIMIT_DEF,
  parameter int          SETTLE_UPDATES = SETTLE_UPDATES_DEF,
  parameter logic [15:0] ERR_WINDOW     = ERR_WINDOW_DEF,
  parameter logic [15:0] SEARCH_STEP    = SEARCH_STEP_DEF,
  parameter logic [15:0] SEARCH_MIN     = SEARCH_MIN_DEF,
  parameter logic [15:0] SEARCH_MAX     = SEARCH_MAX_DEF
) (
  input  logic               clk,
  input  logic               sclr_n,
  input  logic               lock_request,
  input  logic signed [15:0] errorsig,
  input  logic               errorsig_valid,
  input  logic               pi_regout_update,
  input  logic               pi_overflow,
  input  logic               pi_underflow,
  output logic               pi_enable,
  output logic               pi_sclr,
  output logic [15:0]        pi_output_offset,
  output logic               pi_set_output_offset,
  output logic               pi_set_output_clk,
  output logic               locked,
  output logic [2:0]         state,
  output logic [15:0]        relock_count
);

  localparam int SETW = $clog2(SETTLE_UPDATES + 1);
  localparam int SATW = $clog2(SAT_LIMIT + 1);

  state_e            r_state;
  state_e            w_nxt;
  logic [SETW-1:0]   r_settle;
  logic [SATW-1:0]   r_sat;
  logic [15:0]       r_relock;
  logic              r_enable;
  logic              r_sclr;
  logic              r_locked;

  logic              w_load_min;
  logic              w_step;
  logic              w_settle_inc;
  logic              w_sat_inc;
  logic              w_relock;
  logic              w_sat;
  logic [16:0]       w_err_abs;
  logic [15:0]       w_offset;
  logic              w_step_done;

  always_comb begin
    w_nxt        = r_state;
    w_step       = 1'b0;
    w_settle_inc = 1'b0;
    w_sat_inc    = 1'b0;
    w_relock     = 1'b0;
    w_sat        = pi_overflow | pi_underflow;
    w_err_abs    = abs17(errorsig);

    if (!lock_request) begin
      w_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_nxt = ST_CLEAR;
        ST_CLEAR: w_nxt = ST_SEARCH;
        ST_SEARCH: begin
          if (errorsig_valid) begin
            if (w_err_abs < {1'b0, ERR_WINDOW}) w_nxt  = ST_CAPTURE;
            else                                w_step = 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (pi_regout_update) begin
            if (w_sat) begin
              w_nxt    = ST_CLEAR;
              w_relock = 1'b1;
            end else if (r_settle == SETW'(SETTLE_UPDATES - 1)) begin
              w_nxt = ST_LOCKED;
            end else begin
              w_settle_inc = 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (pi_regout_update && w_sat) begin
            if (r_sat == SATW'(SAT_LIMIT - 1)) begin
              w_nxt    = ST_CLEAR;
              w_relock = 1'b1;
            end else begin
              w_sat_inc = 1'b1;
            end
          end
        end
        default: w_nxt = ST_IDLE;
      endcase
    end

    // CLEAR is always left after one cycle, so this fires exactly once per entry.
    w_load_min = (w_nxt == ST_CLEAR);
  end

  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      r_state  <= ST_IDLE;
      r_settle <= '0;
      r_sat    <= '0;
      r_relock <= '0;
      r_enable <= 1'b0;
      r_sclr   <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_enable <= (w_nxt == ST_CAPTURE) || (w_nxt == ST_LOCKED);
      r_locked <= (w_nxt == ST_LOCKED);
      r_sclr   <= w_load_min;

      // Counters only live inside their own state, so entry always sees zero.
      if (w_nxt != ST_CAPTURE) r_settle <= '0;
      else if (w_settle_inc)   r_settle <= r_settle + 1'b1;

      // A clean update in LOCKED restarts the consecutive-saturation run.
      if (w_nxt != ST_LOCKED)                           r_sat <= '0;
      else if (w_sat_inc)                               r_sat <= r_sat + 1'b1;
      else if (pi_regout_update && r_state == ST_LOCKED) r_sat <= '0;

      if (w_relock && (r_relock != 16'hFFFF)) r_relock <= r_relock + 1'b1;
    end
  end

  offset_sweeper #(
    .STEP (SEARCH_STEP),
    .MIN  (SEARCH_MIN),
    .MAX  (SEARCH_MAX)
  ) u_sweep (
    .clk       (clk),
    .sclr_n    (sclr_n),
    .load_min  (w_load_min),
    .step      (w_step),
    .offset    (w_offset),
    .step_done (w_step_done)
  );

  assign pi_enable            = r_enable;
  assign pi_sclr              = r_sclr;
  assign pi_output_offset     = w_offset;
  assign pi_set_output_offset = w_step_done;
  assign pi_set_output_clk    = w_step_done;
  assign locked               = r_locked;
  assign state                = r_state;
  assign relock_count         = r_relock;

endmodule
